// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad peripheral: scan FSM states,
// the (row,col) -> key code table and the two control key codes.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD
  } scan_state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Indexed by {row, col}; row 3 is the "* 0 # D" row.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

endpackage

// File: rtl/keypad_if.sv
// CPU-facing bus of the keypad peripheral: key events, live entry, committed value
// and the ready/rd read handshake.
interface keypad_if;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [31:0] entry;
  logic [31:0] dout;
  logic        ready;
  logic        overrun;
  logic        rd;

  modport master (
    input  key_strobe, key_code, entry, dout, ready, overrun,
    output rd
  );

  modport slave (
    output key_strobe, key_code, entry, dout, ready, overrun,
    input  rd
  );
endinterface

// File: rtl/keypad_scanner.sv
// Column scanner, row synchroniser, per-scan key resolution and debounce FSM.
// Emits a one-cycle key_strobe with the decoded key_code per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_strobe,
  output logic [3:0] key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [1:0]       hit_cnt_q, hit_cnt_d;
  logic [3:0]       hit_idx_q, hit_idx_d;
  scan_state_e      state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_strobe_q, key_strobe_d;
  logic [3:0]       key_code_q, key_code_d;

  logic       sample, scan_done, single;
  logic [3:0] lows;
  logic [2:0] pc, sum;
  logic [1:0] merged_cnt;
  logic [3:0] merged_idx;

  assign col_out    = ~(4'b0001 << col_idx_q);
  assign key_strobe = key_strobe_q;
  assign key_code   = key_code_q;

  always_comb begin
    div_d     = div_q + DIV_W'(1);
    col_idx_d = col_idx_q;
    sample    = (div_q == DIV_LAST);
    if (sample) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
    end
  end

  // Accumulate low rows over the four columns; hit count saturates at 2 (= ghost).
  always_comb begin
    lows       = ~row_s2_q;
    pc         = popcount4(lows);
    sum        = {1'b0, hit_cnt_q} + pc;
    merged_cnt = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    merged_idx = (pc == 3'd1) ? {low_row(lows), col_idx_q} : hit_idx_q;
    hit_cnt_d  = hit_cnt_q;
    hit_idx_d  = hit_idx_q;
    scan_done  = 1'b0;
    single     = (merged_cnt == 2'd1);
    if (sample) begin
      if (col_idx_q == 2'd3) begin
        scan_done = 1'b1;
        hit_cnt_d = '0;
        hit_idx_d = '0;
      end else begin
        hit_cnt_d = merged_cnt;
        hit_idx_d = merged_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    key_strobe_d = 1'b0;
    key_code_d   = key_code_q;
    if (scan_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (single) begin
            state_d = ST_DEBOUNCE;
            cand_d  = merged_idx;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (single && merged_idx == cand_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_DONE) begin
              key_strobe_d = 1'b1;
              key_code_d   = KEYMAP[cand_q];
              state_d      = ST_HELD;
              cnt_d        = '0;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (single) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_DONE) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      col_idx_q    <= '0;
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      hit_cnt_q    <= '0;
      hit_idx_q    <= '0;
      state_q      <= ST_IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      key_strobe_q <= 1'b0;
      key_code_q   <= '0;
    end else begin
      div_q        <= div_d;
      col_idx_q    <= col_idx_d;
      row_s1_q     <= row_in;
      row_s2_q     <= row_s1_q;
      hit_cnt_q    <= hit_cnt_d;
      hit_idx_q    <= hit_idx_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      key_strobe_q <= key_strobe_d;
      key_code_q   <= key_code_d;
    end
  end

endmodule

// File: rtl/keypad_peripheral.sv
// Keypad peripheral top: scanner plus the entry shift register, commit register
// and the ready/overrun read handshake toward the CPU.
module keypad_peripheral
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  keypad_if.slave    bus
);

  logic        key_strobe;
  logic [3:0]  key_code;
  logic [31:0] entry_q, entry_d;
  logic [31:0] dout_q, dout_d;
  logic        ready_q, ready_d;
  logic        overrun_q, overrun_d;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_strobe (key_strobe),
    .key_code   (key_code)
  );

  assign bus.key_strobe = key_strobe;
  assign bus.key_code   = key_code;
  assign bus.entry      = entry_q;
  assign bus.dout       = dout_q;
  assign bus.ready      = ready_q;
  assign bus.overrun    = overrun_q;

  // A commit outranks a simultaneous rd: the new value is unread, but nothing was lost.
  always_comb begin
    entry_d   = entry_q;
    dout_d    = dout_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (key_strobe && key_code == KEY_HASH) begin
      dout_d    = entry_q;
      entry_d   = '0;
      ready_d   = 1'b1;
      overrun_d = (overrun_q | ready_q) & ~bus.rd;
    end else begin
      if (key_strobe && key_code == KEY_STAR) entry_d = '0;
      else if (key_strobe)                    entry_d = {entry_q[27:0], key_code};
      if (bus.rd) begin
        ready_d   = 1'b0;
        overrun_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q   <= '0;
      dout_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      entry_q   <= entry_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_keypad_peripheral.sv
// Directed bench for keypad_peripheral with a behavioural 4x4 matrix keypad model.
module tb_keypad_peripheral;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_CLK = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] pressed = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          strobes = 0;

  keypad_if bus();

  keypad_peripheral #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // A pressed switch shorts its row to its column while that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) if (bus.key_strobe) strobes++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int key_pos(input logic [3:0] code);
    case (code)
      4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
      4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
      4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
      4'hE: return 12; 4'h0: return 13; 4'hF: return 14; default: return 15;
    endcase
  endfunction

  task automatic wait_scans(input int n);
    repeat (n * SCAN_CLK) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code, input int hold_scans);
    @(negedge clk);
    pressed = 16'(1) << key_pos(code);
    wait_scans(hold_scans);
    pressed = '0;
    wait_scans(4);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  // Raise rd exactly in the cycle the '#' strobe is presented.
  task automatic press_hash_with_rd();
    bit seen = 0;
    @(negedge clk);
    pressed = 16'(1) << key_pos(4'hF);
    for (int i = 0; i < 8 * SCAN_CLK && !seen; i++) begin
      @(negedge clk);
      if (bus.key_strobe) begin
        seen = 1;
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
      end
    end
    check("hash_strobe_seen", 32'(seen), 32'd1);
    pressed = '0;
    wait_scans(4);
  endtask

  int s0;

  initial begin
    bus.rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("por_col_out", 32'(col_out), 32'h0000000E);
    check("por_ready", 32'(bus.ready), 32'd0);

    // Preload some state, then reset in the middle of a debounce.
    press(4'h3, 4);
    press(4'hF, 4);
    press(4'h6, 4);
    check("pre_dout", bus.dout, 32'h3);
    check("pre_entry", bus.entry, 32'h6);
    check("pre_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    pressed = 16'(1) << key_pos(4'h5);
    repeat (SCAN_CLK + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_col_out", 32'(col_out), 32'h0000000E);
    check("rst_entry", bus.entry, 32'h0);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_strobe", 32'(bus.key_strobe), 32'd0);
    check("rst_code", 32'(bus.key_code), 32'd0);
    pressed = '0;
    @(negedge clk);
    s0 = strobes;
    rst = 1'b0;
    wait_scans(6);
    check("rst_no_strobe", 32'(strobes - s0), 32'd0);

    // Long hold produces exactly one strobe.
    s0 = strobes;
    press(4'h5, 10);
    check("hold5_strobes", 32'(strobes - s0), 32'd1);
    check("hold5_code", 32'(bus.key_code), 32'h5);
    check("hold5_entry", bus.entry, 32'h5);

    // Commit and read.
    press(4'hE, 4);
    check("star_clear", bus.entry, 32'h0);
    press(4'h1, 4); press(4'h2, 4); press(4'h3, 4); press(4'hA, 4);
    check("entry_123A", bus.entry, 32'h123A);
    press(4'hF, 4);
    check("commit_dout", bus.dout, 32'h0000123A);
    check("commit_ready", 32'(bus.ready), 32'd1);
    check("commit_entry", bus.entry, 32'h0);
    check("commit_code", 32'(bus.key_code), 32'hF);
    pulse_rd();
    check("rd_ready", 32'(bus.ready), 32'd0);
    check("rd_dout_hold", bus.dout, 32'h0000123A);

    // Nine digits drop the first one.
    for (int k = 1; k <= 9; k++) press(4'(k), 4);
    check("nine_digits", bus.entry, 32'h23456789);
    press(4'hE, 4);
    check("nine_star", bus.entry, 32'h0);

    // Bouncing contact and ghosting combination.
    s0 = strobes;
    @(negedge clk);
    for (int t = 0; t < 6; t++) begin
      pressed = (t % 2 == 0) ? (16'(1) << key_pos(4'h7)) : 16'h0;
      wait_scans(1);
    end
    pressed = '0;
    wait_scans(4);
    check("bounce_no_strobe", 32'(strobes - s0), 32'd0);
    s0 = strobes;
    @(negedge clk);
    pressed = (16'(1) << key_pos(4'h1)) | (16'(1) << key_pos(4'h2));
    wait_scans(6);
    pressed = '0;
    wait_scans(4);
    check("ghost_no_strobe", 32'(strobes - s0), 32'd0);
    check("ghost_entry", bus.entry, 32'h0);

    // Overrun and rd/commit collision.
    press(4'h4, 4); press(4'hF, 4);
    check("ovr_first_ready", 32'(bus.ready), 32'd1);
    check("ovr_first_flag", 32'(bus.overrun), 32'd0);
    press(4'h7, 4); press(4'hF, 4);
    check("ovr_dout", bus.dout, 32'h7);
    check("ovr_flag", 32'(bus.overrun), 32'd1);
    check("ovr_ready", 32'(bus.ready), 32'd1);
    pulse_rd();
    check("ovr_rd_flag", 32'(bus.overrun), 32'd0);
    check("ovr_rd_ready", 32'(bus.ready), 32'd0);
    press(4'h8, 4); press(4'hF, 4);
    press(4'h9, 4);
    press_hash_with_rd();
    check("coll_ready", 32'(bus.ready), 32'd1);
    check("coll_overrun", 32'(bus.overrun), 32'd0);
    check("coll_dout", bus.dout, 32'h9);
    pulse_rd();
    check("idle_rd_ready", 32'(bus.ready), 32'd0);
    pulse_rd();
    check("idle_rd_ignored", 32'(bus.dout), 32'h9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
